ctrl_sequencer: RTL and testbench
=================================

Name: ctrl_sequencer

Overview:
- Microsequencer that generates the per-cycle datapath control strobes for the single-bus datapath.
- Runs instruction fetch, then the execute steps for register ALU, unary, multiply/divide, nop and halt instructions.
- Replaces hand-sequenced T0..T6 control with a synthesisable FSM.
- Adds a variable-latency memory handshake, a run/halt gate and HI/LO writeback.

Parameters:
- OPC_W, 5, opcode field width, IR[31:31-OPC_W+1].
- REG_W, 4, register-select field width; Ra/Rb/Rc follow the opcode, MSB first.
- ALU_W, 5, width of alu_op output.
- MUL_OPC, 5'h0E, opcode for mul Rb,Rc to HI/LO.
- DIV_OPC, 5'h0F, opcode for div Rb,Rc to HI/LO.
- NEG_OPC, 5'h09, unary negate.
- NOT_OPC, 5'h0A, unary not.
- NOP_OPC, 5'h1A, no operation.
- HALT_OPC, 5'h1B, halt.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  asynchronous active-low reset.
- run  in  1  level; a 1 allows a new fetch to start.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- ir  in  32  instruction register contents.
- PCout, IncPC, MARin, Zin, Zlowout, ZHighout, Read, MDRin, MDRout, IRin, Yin, HIin, LOin  out  1 each  datapath strobes.
- rout_en  out  1  drive register rout_sel onto the bus.
- rout_sel  out  REG_W  register index to drive.
- rin_en  out  1  load register rin_sel from the bus.
- rin_sel  out  REG_W  register index to load.
- alu_op  out  ALU_W  ALU function; equals the opcode, zero-extended or truncated to ALU_W.
- halted  out  1  sequencer stopped on HALT.
- step  out  4  current state encoding, for debug and the bench.

Behaviour:
- Outputs are Moore, decoded from the registered state and ir only. Every strobe not listed for a state is 0.
- Reset (clear=0, asynchronous):
  - state=IDLE, all outputs 0, step=0.
  - Mid-instruction reset abandons the instruction; no register or HI/LO write strobe may be asserted during or after it.
- State encodings: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- IDLE: all strobes 0. If run=1, go to T0; else stay.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin-equivalent via rin? No; Zlowout with PC load is external. Assert Zlowout, Read, MDRin.
  - Stay in T1 while mem_ready=0; Read and MDRin hold for every wait cycle.
  - When mem_ready=1, go to T2.
- T2: MDRout, IRin. Go to T3.
- T3, decoded from ir opcode:
  - HALT_OPC: no strobes; go to HALT.
  - NOP_OPC: no strobes; go to IDLE if run=0, else T0.
  - NEG_OPC/NOT_OPC: rout_en with rout_sel=Rb, alu_op, Zin; go to T5 (no Y load).
  - Any other opcode (two-operand, including MUL/DIV): rout_en with rout_sel=Rb, Yin; go to T4.
- T4: rout_en with rout_sel=Rc, alu_op, Zin. Go to T5.
- T5:
  - MUL/DIV: Zlowout, LOin; go to T6.
  - Otherwise: Zlowout, rin_en with rin_sel=Ra; go to IDLE if run=0, else T0.
- T6 (MUL/DIV only): ZHighout, HIin. Go to IDLE if run=0, else T0.
- HALT: halted=1, all strobes 0. Exit only via clear.
- run sampling: run is sampled only in IDLE and in the final execute state. Deasserting run mid-instruction completes the current instruction.
- Bus exclusivity: at most one of PCout, MDRout, Zlowout, ZHighout, rout_en is 1 in any cycle.
- Latency: with mem_ready tied to 1:
  - ALU op: 6 cycles T0..T5.
  - MUL/DIV: 7 cycles.
  - Unary: 5 cycles.
  - NOP: 4 cycles.
- Each mem_ready=0 cycle in T1 adds one cycle.
- ir changes outside T3..T6 have no effect. ir is sampled combinationally in T3..T6 and is stable there because IRin is deasserted.

Test Plan:
- Reset, then run=1, mem_ready=1, ir=and R1,R2,R3 (opcode 0x05, Ra=1, Rb=2, Rc=3):
  - step sequence 1,2,3,4,5,6.
  - T3: rout_sel=2 with Yin.
  - T4: rout_sel=3, alu_op=5, Zin.
  - T5: rin_sel=1, Zlowout.
  - Then back to T0.
- mul R0,R4,R5 with mem_ready low for 3 cycles in T1:
  - T1 lasts 4 cycles with Read=1 throughout.
  - T5: LOin=1. T6: ZHighout=1, HIin=1.
  - Total 10 cycles.
- not R6,R7 (0x0A): T3 asserts rout_sel=7, Zin, and no Yin; T4 is skipped; T5 has rin_sel=6.
- run=0 asserted during T4 of add: instruction completes through T5, then IDLE; all strobes stay 0 until run=1.
- HALT_OPC fetched: halted=1 from the cycle after T3; run toggling has no effect; clear=0 returns step=0.
- clear pulsed low asynchronously mid-T4: all outputs drop to 0 before the next clock edge; rin_en never asserts for that instruction.
- Every cycle of every scenario: a checker asserts bus exclusivity.

Source files
------------

// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the microsequencer and the single-bus datapath.
// Valid/ready semantics: the memory presents read data on Mdatain and raises
// mem_ready in the same cycle. The sequencer keeps Read/MDRin asserted in T1
// every cycle until it samples mem_ready=1 on a rising clock edge, and only
// then advances. run is a level that is sampled only at instruction
// boundaries. All sequencer outputs are registered-state decodes (Moore).
interface ctrl_sequencer_if #(
  parameter int REG_W = 4,
  parameter int ALU_W = 5
);
  logic              run;
  logic              mem_ready;
  logic [31:0]       ir;

  logic              PCout;
  logic              IncPC;
  logic              MARin;
  logic              Zin;
  logic              Zlowout;
  logic              ZHighout;
  logic              Read;
  logic              MDRin;
  logic              MDRout;
  logic              IRin;
  logic              Yin;
  logic              HIin;
  logic              LOin;
  logic              rout_en;
  logic [REG_W-1:0]  rout_sel;
  logic              rin_en;
  logic [REG_W-1:0]  rin_sel;
  logic [ALU_W-1:0]  alu_op;
  logic              halted;
  logic [3:0]        step;

  // Sequencer side: consumes run/mem_ready/ir, produces strobes.
  modport master (
    input  run, mem_ready, ir,
    output PCout, IncPC, MARin, Zin, Zlowout, ZHighout, Read, MDRin, MDRout,
           IRin, Yin, HIin, LOin, rout_en, rout_sel, rin_en, rin_sel, alu_op,
           halted, step
  );

  // Datapath / environment side.
  modport slave (
    output run, mem_ready, ir,
    input  PCout, IncPC, MARin, Zin, Zlowout, ZHighout, Read, MDRin, MDRout,
           IRin, Yin, HIin, LOin, rout_en, rout_sel, rin_en, rin_sel, alu_op,
           halted, step
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Microsequencer for the single-bus datapath: fetch (T0..T2) followed by
// execute steps for two-operand ALU, unary, mul/div (HI/LO), nop and halt.
// Outputs are decoded from the registered state and ir only; step exposes
// the state encoding for debug.
module ctrl_sequencer #(
  parameter int               OPC_W    = 5,
  parameter int               REG_W    = 4,
  parameter int               ALU_W    = 5,
  parameter logic [OPC_W-1:0] MUL_OPC  = 5'h0E,
  parameter logic [OPC_W-1:0] DIV_OPC  = 5'h0F,
  parameter logic [OPC_W-1:0] NEG_OPC  = 5'h09,
  parameter logic [OPC_W-1:0] NOT_OPC  = 5'h0A,
  parameter logic [OPC_W-1:0] NOP_OPC  = 5'h1A,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'h1B
) (
  input  logic              clock,
  input  logic              clear,
  ctrl_sequencer_if.master  bus
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T2   = 4'd3;
  localparam logic [3:0] S_T3   = 4'd4;
  localparam logic [3:0] S_T4   = 4'd5;
  localparam logic [3:0] S_T5   = 4'd6;
  localparam logic [3:0] S_T6   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  // Instruction fields: opcode at the top, then Ra, Rb, Rc, MSB first.
  localparam int RA_MSB  = 31 - OPC_W;
  localparam int FLD_LSB = RA_MSB - 3 * REG_W;

  logic [3:0]       state;
  logic [3:0]       state_nx;
  logic [OPC_W-1:0] opcode;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;
  logic [REG_W-1:0] rc;
  logic [31:0]      opc_ext;
  logic [ALU_W-1:0] alu_val;
  logic             is_muldiv;
  logic             is_unary;
  logic             unused_bits;

  assign opcode  = bus.ir[31 -: OPC_W];
  assign ra      = bus.ir[RA_MSB -: REG_W];
  assign rb      = bus.ir[RA_MSB - REG_W -: REG_W];
  assign rc      = bus.ir[RA_MSB - 2 * REG_W -: REG_W];

  // alu_op is the opcode zero-extended or truncated to ALU_W.
  assign opc_ext = 32'(opcode);
  assign alu_val = opc_ext[ALU_W-1:0];

  assign is_muldiv = (opcode == MUL_OPC) || (opcode == DIV_OPC);
  assign is_unary  = (opcode == NEG_OPC) || (opcode == NOT_OPC);

  // Immediate/low ir bits and upper extension bits carry no control meaning.
  assign unused_bits = ^{bus.ir[FLD_LSB:0], opc_ext[31:ALU_W]};

  // State register; clear abandons any instruction in flight.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: run is looked at only in IDLE and the last execute step.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (bus.run) state_nx = S_T0;
      S_T0:   state_nx = S_T1;
      S_T1:   if (bus.mem_ready) state_nx = S_T2;
      S_T2:   state_nx = S_T3;
      S_T3: begin
        if (opcode == HALT_OPC)     state_nx = S_HALT;
        else if (opcode == NOP_OPC) state_nx = bus.run ? S_T0 : S_IDLE;
        else if (is_unary)          state_nx = S_T5;
        else                        state_nx = S_T4;
      end
      S_T4:   state_nx = S_T5;
      S_T5: begin
        if (is_muldiv) state_nx = S_T6;
        else           state_nx = bus.run ? S_T0 : S_IDLE;
      end
      S_T6:   state_nx = bus.run ? S_T0 : S_IDLE;
      S_HALT: state_nx = S_HALT;
      default: state_nx = S_IDLE;
    endcase
  end

  // Moore strobe decode; anything not named for a state stays 0.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.ZHighout = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.rout_en  = 1'b0;
    bus.rout_sel = '0;
    bus.rin_en   = 1'b0;
    bus.rin_sel  = '0;
    bus.alu_op   = '0;
    bus.halted   = 1'b0;
    bus.step     = state;
    case (state)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if ((opcode != HALT_OPC) && (opcode != NOP_OPC)) begin
          bus.rout_en  = 1'b1;
          bus.rout_sel = rb;
          if (is_unary) begin
            bus.alu_op = alu_val;
            bus.Zin    = 1'b1;
          end else begin
            bus.Yin = 1'b1;
          end
        end
      end
      S_T4: begin
        bus.rout_en  = 1'b1;
        bus.rout_sel = rc;
        bus.alu_op   = alu_val;
        bus.Zin      = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_muldiv) begin
          bus.LOin = 1'b1;
        end else begin
          bus.rin_en  = 1'b1;
          bus.rin_sel = ra;
        end
      end
      S_T6: begin
        bus.ZHighout = 1'b1;
        bus.HIin     = 1'b1;
      end
      S_HALT: bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-scenario tasks with hand-computed
// step/strobe sequences, run from one initial block.
module tb_ctrl_sequencer;

  logic clock = 1'b0;
  logic clear;
  int   vectors = 0;
  int   miscompares = 0;

  ctrl_sequencer_if #(.REG_W(4), .ALU_W(5)) bus ();

  ctrl_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Strobe bit masks, MSB first in the order of strb below.
  localparam logic [14:0] M_PCOUT  = 15'h4000;
  localparam logic [14:0] M_INCPC  = 15'h2000;
  localparam logic [14:0] M_MARIN  = 15'h1000;
  localparam logic [14:0] M_ZIN    = 15'h0800;
  localparam logic [14:0] M_ZLO    = 15'h0400;
  localparam logic [14:0] M_ZHI    = 15'h0200;
  localparam logic [14:0] M_READ   = 15'h0100;
  localparam logic [14:0] M_MDRIN  = 15'h0080;
  localparam logic [14:0] M_MDROUT = 15'h0040;
  localparam logic [14:0] M_IRIN   = 15'h0020;
  localparam logic [14:0] M_YIN    = 15'h0010;
  localparam logic [14:0] M_HIIN   = 15'h0008;
  localparam logic [14:0] M_LOIN   = 15'h0004;
  localparam logic [14:0] M_ROUT   = 15'h0002;
  localparam logic [14:0] M_RIN    = 15'h0001;

  localparam logic [14:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [14:0] E_T1 = M_ZLO | M_READ | M_MDRIN;
  localparam logic [14:0] E_T2 = M_MDROUT | M_IRIN;

  logic [14:0] strb;
  logic [4:0]  bus_drv;

  assign strb = {bus.PCout, bus.IncPC, bus.MARin, bus.Zin, bus.Zlowout,
                 bus.ZHighout, bus.Read, bus.MDRin, bus.MDRout, bus.IRin,
                 bus.Yin, bus.HIin, bus.LOin, bus.rout_en, bus.rin_en};
  assign bus_drv = {bus.PCout, bus.MDRout, bus.Zlowout, bus.ZHighout, bus.rout_en};

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {opc, ra, rb, rc, 15'h0};
  endfunction

  // Advance one clock, sample 1 time unit after the edge, and check that at
  // most one bus driver is active in the new cycle.
  task automatic tick;
    @(posedge clock);
    #1;
    vectors++;
    if ($countones(bus_drv) > 1) begin
      miscompares++;
      $display("FAIL bus_excl step=%0d drivers=%b required at most one set", bus.step, bus_drv);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 30 && bus.step !== 4'd0; n++) tick();
    vectors++;
    if (bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL %s idle_timeout step=%0d required 0", tag, bus.step);
    end
  endtask

  task automatic test_reset;
    clear = 1'b0;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.ir = '0;
    #3;
    vectors++;
    if (bus.step !== 4'd0 || strb !== 15'h0 || bus.halted !== 1'b0 ||
        bus.alu_op !== 5'h0 || bus.rout_sel !== 4'h0 || bus.rin_sel !== 4'h0) begin
      miscompares++;
      $display("FAIL reset_outputs step=%0d strb=%h halted=%b alu=%h required all 0",
               bus.step, strb, bus.halted, bus.alu_op);
    end
    tick();
    tick();
    @(negedge clock);
    clear = 1'b1;
    tick();
    vectors++;
    if (bus.step !== 4'd0 || strb !== 15'h0) begin
      miscompares++;
      $display("FAIL reset_idle step=%0d strb=%h required step=0 strb=0", bus.step, strb);
    end
  endtask

  task automatic test_alu;
    logic [3:0]  es [6];
    logic [14:0] em [6];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    em = '{E_T0, E_T1, E_T2, M_ROUT | M_YIN, M_ROUT | M_ZIN, M_ZLO | M_RIN};
    bus.ir = mk_ir(5'h05, 4'd1, 4'd2, 4'd3);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.step !== es[i] || strb !== em[i]) begin
        miscompares++;
        $display("FAIL alu_seq i=%0d got step=%0d strb=%h need step=%0d strb=%h",
                 i, bus.step, strb, es[i], em[i]);
      end
      if (i == 3) begin
        vectors++;
        if (bus.rout_sel !== 4'd2) begin
          miscompares++;
          $display("FAIL alu_t3_sel got %0d need 2", bus.rout_sel);
        end
      end
      if (i == 4) begin
        vectors++;
        if (bus.rout_sel !== 4'd3 || bus.alu_op !== 5'h05) begin
          miscompares++;
          $display("FAIL alu_t4 got sel=%0d alu=%h need sel=3 alu=05", bus.rout_sel, bus.alu_op);
        end
      end
      if (i == 5) begin
        vectors++;
        if (bus.rin_sel !== 4'd1) begin
          miscompares++;
          $display("FAIL alu_t5_rin got %0d need 1", bus.rin_sel);
        end
      end
      tick();
    end
    vectors++;
    if (bus.step !== 4'd1) begin
      miscompares++;
      $display("FAIL alu_back_to_t0 got step=%0d need 1", bus.step);
    end
    bus.run = 1'b0;
    wait_idle("alu");
  endtask

  task automatic test_mul_wait;
    logic [3:0]  es [10];
    logic [14:0] em [10];
    es = '{4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    em = '{E_T0, E_T1, E_T1, E_T1, E_T1, E_T2, M_ROUT | M_YIN, M_ROUT | M_ZIN,
           M_ZLO | M_LOIN, M_ZHI | M_HIIN};
    bus.ir = mk_ir(5'h0E, 4'd0, 4'd4, 4'd5);
    bus.mem_ready = 1'b0;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.mem_ready = (i >= 4);
      vectors++;
      if (bus.step !== es[i] || strb !== em[i]) begin
        miscompares++;
        $display("FAIL mul_seq i=%0d got step=%0d strb=%h need step=%0d strb=%h",
                 i, bus.step, strb, es[i], em[i]);
      end
      if (i == 6) begin
        vectors++;
        if (bus.rout_sel !== 4'd4) begin
          miscompares++;
          $display("FAIL mul_t3_sel got %0d need 4", bus.rout_sel);
        end
      end
      if (i == 7) begin
        vectors++;
        if (bus.rout_sel !== 4'd5 || bus.alu_op !== 5'h0E) begin
          miscompares++;
          $display("FAIL mul_t4 got sel=%0d alu=%h need sel=5 alu=0e", bus.rout_sel, bus.alu_op);
        end
      end
      tick();
    end
    vectors++;
    if (bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL mul_total_10 got step=%0d need 0", bus.step);
    end
  endtask

  task automatic test_unary;
    logic [3:0]  es [5];
    logic [14:0] em [5];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
    em = '{E_T0, E_T1, E_T2, M_ROUT | M_ZIN, M_ZLO | M_RIN};
    bus.ir = mk_ir(5'h0A, 4'd6, 4'd7, 4'd0);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.step !== es[i] || strb !== em[i]) begin
        miscompares++;
        $display("FAIL not_seq i=%0d got step=%0d strb=%h need step=%0d strb=%h",
                 i, bus.step, strb, es[i], em[i]);
      end
      if (i == 3) begin
        vectors++;
        if (bus.rout_sel !== 4'd7 || bus.alu_op !== 5'h0A) begin
          miscompares++;
          $display("FAIL not_t3 got sel=%0d alu=%h need sel=7 alu=0a", bus.rout_sel, bus.alu_op);
        end
      end
      if (i == 4) begin
        vectors++;
        if (bus.rin_sel !== 4'd6) begin
          miscompares++;
          $display("FAIL not_t5_rin got %0d need 6", bus.rin_sel);
        end
      end
      tick();
    end
    vectors++;
    if (bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL not_end got step=%0d need 0", bus.step);
    end
  endtask

  task automatic test_run_stop;
    logic [3:0]  es [6];
    logic [14:0] em [6];
    es = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    em = '{E_T0, E_T1, E_T2, M_ROUT | M_YIN, M_ROUT | M_ZIN, M_ZLO | M_RIN};
    bus.ir = mk_ir(5'h03, 4'd4, 4'd5, 4'd6);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.run = 1'b0;
      vectors++;
      if (bus.step !== es[i] || strb !== em[i]) begin
        miscompares++;
        $display("FAIL runstop_seq i=%0d got step=%0d strb=%h need step=%0d strb=%h",
                 i, bus.step, strb, es[i], em[i]);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.step !== 4'd0 || strb !== 15'h0) begin
        miscompares++;
        $display("FAIL runstop_idle i=%0d got step=%0d strb=%h need 0/0", i, bus.step, strb);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  es [4];
    logic [14:0] em [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd4};
    em = '{E_T0, E_T1, E_T2, 15'h0};
    bus.ir = mk_ir(5'h1A, 4'd0, 4'd0, 4'd0);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.step !== es[i] || strb !== em[i]) begin
        miscompares++;
        $display("FAIL nop_seq i=%0d got step=%0d strb=%h need step=%0d strb=%h",
                 i, bus.step, strb, es[i], em[i]);
      end
      tick();
    end
    vectors++;
    if (bus.step !== 4'd1) begin
      miscompares++;
      $display("FAIL nop_back_to_t0 got step=%0d need 1", bus.step);
    end
    bus.run = 1'b0;
    wait_idle("nop");
  endtask

  task automatic test_halt;
    logic [3:0]  es [4];
    logic [14:0] em [4];
    es = '{4'd1, 4'd2, 4'd3, 4'd4};
    em = '{E_T0, E_T1, E_T2, 15'h0};
    bus.ir = mk_ir(5'h1B, 4'd0, 4'd0, 4'd0);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.step !== es[i] || strb !== em[i] || bus.halted !== 1'b0) begin
        miscompares++;
        $display("FAIL halt_seq i=%0d got step=%0d strb=%h halted=%b need step=%0d strb=%h halted=0",
                 i, bus.step, strb, bus.halted, es[i], em[i]);
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.step !== 4'd8 || bus.halted !== 1'b1 || strb !== 15'h0) begin
        miscompares++;
        $display("FAIL halt_hold i=%0d got step=%0d halted=%b strb=%h need 8/1/0",
                 i, bus.step, bus.halted, strb);
      end
      bus.run = ~bus.run;
      tick();
    end
    clear = 1'b0;
    #1;
    vectors++;
    if (bus.step !== 4'd0 || bus.halted !== 1'b0 || strb !== 15'h0) begin
      miscompares++;
      $display("FAIL halt_clear got step=%0d halted=%b strb=%h need 0/0/0", bus.step, bus.halted, strb);
    end
    bus.run = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    tick();
    vectors++;
    if (bus.step !== 4'd0) begin
      miscompares++;
      $display("FAIL halt_after_clear got step=%0d need 0", bus.step);
    end
  endtask

  task automatic test_clear_mid;
    bus.ir = mk_ir(5'h03, 4'd1, 4'd2, 4'd3);
    bus.mem_ready = 1'b1;
    bus.run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (bus.step !== 4'd5 || strb !== (M_ROUT | M_ZIN)) begin
      miscompares++;
      $display("FAIL clrmid_at_t4 got step=%0d strb=%h need step=5 strb=%h", bus.step, strb, M_ROUT | M_ZIN);
    end
    #2;
    clear = 1'b0;
    #1;
    vectors++;
    if (bus.step !== 4'd0 || strb !== 15'h0 || bus.alu_op !== 5'h0 || bus.rout_sel !== 4'h0) begin
      miscompares++;
      $display("FAIL clrmid_async got step=%0d strb=%h alu=%h sel=%0d need all 0",
               bus.step, strb, bus.alu_op, bus.rout_sel);
    end
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.rin_en !== 1'b0 || bus.step !== 4'd0) begin
        miscompares++;
        $display("FAIL clrmid_hold i=%0d got rin_en=%b step=%0d need 0/0", i, bus.rin_en, bus.step);
      end
    end
    @(negedge clock);
    clear = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (bus.rin_en !== 1'b0 || bus.step !== 4'd0) begin
        miscompares++;
        $display("FAIL clrmid_release i=%0d got rin_en=%b step=%0d need 0/0", i, bus.rin_en, bus.step);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul_wait();
    test_unary();
    test_run_stop();
    test_back_to_back();
    test_halt();
    test_clear_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
